// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile-matching turn sequencer.
// Helpers operate on a fixed-width container; callers zero-extend their switch vector.
package tile_pkg;
  localparam int NUM_TILES_DEF = 10;
  localparam int TILE_IDX_W    = $clog2(NUM_TILES_DEF);
  localparam int MAX_TILES     = 64;
  localparam int MAX_IDX_W     = $clog2(MAX_TILES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT1, ST_READ1, ST_WAIT2, ST_READ2, ST_CMP, ST_SHOW, ST_DONE
  } state_e;

  function automatic logic is_onehot(input logic [MAX_TILES-1:0] v);
    return (v != '0) && ((v & (v - MAX_TILES'(1))) == '0);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_idx(input logic [MAX_TILES-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_TILES; i++) begin
      if (v[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer and falling-edge press detector for an active-low button.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);
  logic sync1_q, sync2_q, prev_q, press_q;

  // NOTE: non-blocking assignments make every flop sample the pre-edge values,
  // so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= prev_q & ~sync2_q;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/tile_turn_ctrl.sv
// Two-pick turn sequencer: debounced picks, board reads, compare, and
// matched/revealed masks with score and attempt counters.
module tile_turn_ctrl
  import tile_pkg::*;
#(
  parameter int NUM_TILES     = NUM_TILES_DEF,
  parameter int VAL_W         = 4,
  parameter int REVEAL_CYCLES = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic                          start_n,
  input  logic                          pick1_n,
  input  logic                          pick2_n,
  input  logic [NUM_TILES-1:0]          sel,
  output logic [$clog2(NUM_TILES)-1:0]  tile_addr,
  input  logic [VAL_W-1:0]              tile_val,
  output logic [NUM_TILES-1:0]          matched,
  output logic [NUM_TILES-1:0]          revealed,
  output logic [$clog2(NUM_TILES/2):0]  score,
  output logic [7:0]                    tries,
  output logic                          pick_err,
  output logic                          game_over
);
  localparam int IDX_W   = $clog2(NUM_TILES);
  localparam int SCORE_W = $clog2(NUM_TILES/2) + 1;
  localparam int CNT_W   = $clog2(REVEAL_CYCLES) + 1;
  localparam int PAIRS   = NUM_TILES / 2;

  logic start_p, pick1_p, pick2_p;

  key_edge u_start (.clk(CLOCK_50), .rst_n(resetn), .key_n_i(start_n), .press_o(start_p));
  key_edge u_pick1 (.clk(CLOCK_50), .rst_n(resetn), .key_n_i(pick1_n), .press_o(pick1_p));
  key_edge u_pick2 (.clk(CLOCK_50), .rst_n(resetn), .key_n_i(pick2_n), .press_o(pick2_p));

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx1_q, idx1_d, idx2_q, idx2_d, addr_q, addr_d;
  logic [VAL_W-1:0]     val1_q, val1_d, val2_q, val2_d;
  logic [NUM_TILES-1:0] matched_q, matched_d, revealed_q, revealed_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_inc;
  logic [7:0]           tries_q, tries_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pick_err_q, pick_err_d;

  logic [MAX_TILES-1:0] sel_ext;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_legal, take1, take2, acc1, acc2;

  assign sel_ext   = MAX_TILES'(sel);
  assign sel_idx   = IDX_W'(onehot_idx(sel_ext));
  assign sel_legal = is_onehot(sel_ext) && ((sel & matched_q) == '0);
  // Start wins over any pick landing in the same cycle.
  assign take1     = !start_p && (state_q == ST_WAIT1) && pick1_p;
  assign take2     = !start_p && (state_q == ST_WAIT2) && pick2_p;
  assign acc1      = take1 && sel_legal;
  assign acc2      = take2 && sel_legal && (sel_idx != idx1_q);
  assign score_inc = score_q + SCORE_W'(1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx1_q     <= '0;
      idx2_q     <= '0;
      addr_q     <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      matched_q  <= '0;
      revealed_q <= '0;
      score_q    <= '0;
      tries_q    <= '0;
      cnt_q      <= '0;
      pick_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      addr_q     <= addr_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      matched_q  <= matched_d;
      revealed_q <= revealed_d;
      score_q    <= score_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      pick_err_q <= pick_err_d;
    end
  end

  // NOTE: every _d is given its hold value before any branch, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    addr_d     = addr_q;
    val1_d     = val1_q;
    val2_d     = val2_q;
    matched_d  = matched_q;
    revealed_d = revealed_q;
    score_d    = score_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    pick_err_d = (take1 && !acc1) || (take2 && !acc2);

    if (start_p) begin
      matched_d  = '0;
      revealed_d = '0;
      score_d    = '0;
      tries_d    = '0;
      state_d    = ST_WAIT1;
    end else begin
      case (state_q)
        ST_WAIT1: if (acc1) begin
          idx1_d     = sel_idx;
          addr_d     = sel_idx;
          revealed_d = revealed_q | sel;
          state_d    = ST_READ1;
        end
        ST_READ1: begin
          val1_d  = tile_val;
          state_d = ST_WAIT2;
        end
        ST_WAIT2: if (acc2) begin
          idx2_d     = sel_idx;
          addr_d     = sel_idx;
          revealed_d = revealed_q | sel;
          state_d    = ST_READ2;
        end
        ST_READ2: begin
          val2_d  = tile_val;
          state_d = ST_CMP;
        end
        ST_CMP: begin
          tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
          if (val1_q == val2_q) begin
            matched_d[idx1_q] = 1'b1;
            matched_d[idx2_q] = 1'b1;
            score_d           = score_inc;
            state_d           = (score_inc == SCORE_W'(PAIRS)) ? ST_DONE : ST_WAIT1;
          end else begin
            cnt_d   = CNT_W'(REVEAL_CYCLES - 1);
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            revealed_d[idx1_q] = 1'b0;
            revealed_d[idx2_q] = 1'b0;
            state_d            = ST_WAIT1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The address is presented in the accepting cycle so the synchronous board read lands in READx.
  always_comb begin
    tile_addr = addr_q;
    if (acc1 || acc2) tile_addr = sel_idx;
    game_over = (state_q == ST_DONE);
  end

  assign matched  = matched_q;
  assign revealed = revealed_q;
  assign score    = score_q;
  assign tries    = tries_q;
  assign pick_err = pick_err_q;
endmodule

// File: tb/tb_tile_turn_ctrl.sv
// Self-checking bench for tile_turn_ctrl against a turn-level reference model.
module tb_tile_turn_ctrl;
  import tile_pkg::*;
  localparam int NT = NUM_TILES_DEF;
  localparam int VW = 4;
  localparam int RC = 4;
  localparam int AW = TILE_IDX_W;
  localparam int SW = $clog2(NT/2) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0, start_n = 1'b1, pick1_n = 1'b1, pick2_n = 1'b1;
  logic [NT-1:0] sel = '0;
  logic [AW-1:0] tile_addr;
  logic [VW-1:0] tile_val;
  logic [NT-1:0] matched, revealed;
  logic [SW-1:0] score;
  logic [7:0]    tries;
  logic          pick_err, game_over;

  int checks = 0, failures = 0, err_seen = 0;

  tile_turn_ctrl #(.NUM_TILES(NT), .VAL_W(VW), .REVEAL_CYCLES(RC)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start_n(start_n), .pick1_n(pick1_n),
    .pick2_n(pick2_n), .sel(sel), .tile_addr(tile_addr), .tile_val(tile_val),
    .matched(matched), .revealed(revealed), .score(score), .tries(tries),
    .pick_err(pick_err), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Board memory: synchronous read, value of tile i is i>>1.
  always @(posedge clk) tile_val <= VW'(tile_addr >> 1);
  always @(posedge clk) if (pick_err === 1'b1) err_seen <= err_seen + 1;

  // Turn-level reference model: 0 idle, 1 awaiting first pick, 2 awaiting second, 3 game over.
  int            ph = 0, m_idx1 = 0, m_score = 0, m_tries = 0, exp_err = 0;
  logic [NT-1:0] m_matched = '0, m_revealed = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [NT-1:0] s);
    for (int i = 0; i < NT; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [NT-1:0] onehot_of(input int i);
    logic [NT-1:0] s;
    s = '0;
    s[i] = 1'b1;
    return s;
  endfunction

  function automatic bit legal(input logic [NT-1:0] s);
    return ($countones(s) == 1) && ((s & m_matched) == '0);
  endfunction

  function automatic void model_clear(input int next_ph);
    m_matched = '0; m_revealed = '0; m_score = 0; m_tries = 0; ph = next_ph;
  endfunction

  function automatic void model_pick1(input logic [NT-1:0] s);
    if (ph != 1) return;
    if (legal(s)) begin
      m_idx1 = idx_of(s);
      m_revealed[m_idx1] = 1'b1;
      ph = 2;
    end else exp_err++;
  endfunction

  function automatic void model_pick2(input logic [NT-1:0] s);
    int i2;
    if (ph != 2) return;
    i2 = idx_of(s);
    if (legal(s) && i2 != m_idx1) begin
      if (m_tries < 255) m_tries++;
      if ((i2 / 2) == (m_idx1 / 2)) begin
        m_matched[m_idx1] = 1'b1; m_matched[i2] = 1'b1;
        m_revealed[i2] = 1'b1;
        m_score++;
        ph = (m_score == NT/2) ? 3 : 1;
      end else begin
        m_revealed[m_idx1] = 1'b0;
        ph = 1;
      end
    end else exp_err++;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".matched"},   32'(matched),   32'(m_matched));
    check({tag, ".revealed"},  32'(revealed),  32'(m_revealed));
    check({tag, ".score"},     32'(score),     32'(m_score));
    check({tag, ".tries"},     32'(tries),     32'(m_tries));
    check({tag, ".game_over"}, 32'(game_over), 32'(ph == 3));
    check({tag, ".subset"},    32'(matched & ~revealed), 32'(0));
  endtask

  task automatic act(input bit bs, input bit b1, input bit b2, input logic [NT-1:0] s,
                     input int hold, input string tag);
    int e0, p0;
    sel = s;
    tick(1);
    e0 = err_seen;
    start_n = !bs; pick1_n = !b1; pick2_n = !b2;
    tick(hold);
    start_n = 1'b1; pick1_n = 1'b1; pick2_n = 1'b1;
    tick(RC + 8);
    exp_err = 0;
    p0 = ph;
    if (bs) model_clear(1);
    else begin
      if (b1 && p0 == 1) model_pick1(s);
      if (b2 && p0 == 2) model_pick2(s);
    end
    check({tag, ".pick_err"}, 32'(err_seen - e0), 32'(exp_err));
    check_model(tag);
  endtask

  function automatic logic [NT-1:0] rand_sel(input bit smart);
    int r;
    r = $urandom_range(0, 99);
    if (smart && ph == 2 && r < 50) return onehot_of(m_idx1 ^ 1);
    if (r < 75) return onehot_of($urandom_range(0, NT-1));
    if (r < 90) return NT'($urandom);
    return '0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt, r;
    logic [NT-1:0] s;

    tick(3);
    check("rst.matched",   32'(matched),   0);
    check("rst.revealed",  32'(revealed),  0);
    check("rst.score",     32'(score),     0);
    check("rst.tries",     32'(tries),     0);
    check("rst.tile_addr", 32'(tile_addr), 0);
    check("rst.pick_err",  32'(pick_err),  0);
    check("rst.game_over", 32'(game_over), 0);
    resetn = 1'b1;
    tick(2);

    act(0, 1, 0, 10'h002, 4, "idle_pick_ignored");
    act(1, 0, 0, '0, 4, "start");

    // Mismatch 1 vs 2: revealed=0x006 for exactly RC cycles of SHOW.
    act(0, 1, 0, 10'h002, 4, "mm.pick1");
    sel = 10'h004;
    tick(1);
    pick2_n = 1'b0;
    n = 0;
    while (!(revealed == 10'h006 && tries == 8'd1) && n < 30) begin tick(1); n++; end
    check("mm.reach_show", 32'(n < 30), 1);
    cnt = 0;
    while (revealed == 10'h006 && tries == 8'd1 && cnt < 40) begin cnt++; tick(1); end
    check("mm.show_len", cnt, RC);
    check("mm.revealed_after", 32'(revealed), 0);
    pick2_n = 1'b1;
    tick(RC + 8);
    model_pick2(10'h004);
    check_model("mismatch");

    act(0, 1, 0, 10'h100, 4, "match.pick1");
    act(0, 0, 1, 10'h200, 4, "match.pick2");
    check("match.mask", 32'(matched), 32'h300);

    act(0, 1, 0, 10'h006, 4, "rej.multi");
    act(0, 1, 0, 10'h200, 4, "rej.matched");
    act(0, 1, 0, 10'h001, 4, "rej.p1ok");
    act(0, 0, 1, 10'h001, 4, "rej.same");
    act(0, 0, 1, 10'h002, 4, "rej.p2ok");

    for (int p = 1; p < 4; p++) begin
      act(0, 1, 0, onehot_of(2*p), 4, "game.pick1");
      act(0, 0, 1, onehot_of(2*p+1), 4, "game.pick2");
    end
    check("game.score", 32'(score), 5);
    check("game.over", 32'(game_over), 1);
    check("game.mask", 32'(matched), 32'h3FF);
    act(0, 1, 0, 10'h001, 4, "done.pick_ignored");
    act(1, 0, 0, '0, 4, "done.restart");
    check("restart.over", 32'(game_over), 0);

    // Start pressed while the mismatched pair is on show.
    act(0, 1, 0, 10'h100, 4, "rs.pick1a");
    act(0, 0, 1, 10'h200, 4, "rs.pick2a");
    act(0, 1, 0, 10'h010, 4, "rs.pick1b");
    sel = 10'h040;
    tick(1);
    pick2_n = 1'b0;
    tick(4);
    start_n = 1'b0;
    tick(4);
    pick2_n = 1'b1; start_n = 1'b1;
    tick(RC + 8);
    model_clear(1);
    check_model("restart_show");

    act(0, 1, 0, 10'h006, 50, "held.bad");
    act(0, 1, 0, 10'h020, 50, "held.good");
    act(0, 0, 1, 10'h010, 4, "held.pair");

    // Reset asserted while the second read is in flight.
    act(0, 1, 0, 10'h004, 4, "rr.pick1");
    sel = 10'h008;
    tick(1);
    pick2_n = 1'b0;
    n = 0;
    while (revealed[3] !== 1'b1 && n < 30) begin tick(1); n++; end
    check("rr.reach_read2", 32'(n < 30), 1);
    resetn = 1'b0;
    #1;
    check("rr.matched",   32'(matched),   0);
    check("rr.revealed",  32'(revealed),  0);
    check("rr.score",     32'(score),     0);
    check("rr.tries",     32'(tries),     0);
    check("rr.tile_addr", 32'(tile_addr), 0);
    check("rr.pick_err",  32'(pick_err),  0);
    check("rr.game_over", 32'(game_over), 0);
    tick(1);
    pick2_n = 1'b1;
    tick(2);
    resetn = 1'b1;
    model_clear(0);
    tick(2);
    check_model("after_reset");

    act(1, 0, 0, '0, 4, "rnd.start");
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if ((ph == 3 && r < 40) || r < 3) act(1, 0, 0, '0, $urandom_range(4, 8), "rnd.start");
      else if (r < 48) act(0, 1, 0, rand_sel(0), $urandom_range(4, 8), "rnd.pick1");
      else if (r < 90) act(0, 0, 1, rand_sel(1), $urandom_range(4, 8), "rnd.pick2");
      else begin
        s = rand_sel(1);
        act(0, 1, 1, s, $urandom_range(4, 8), "rnd.both");
      end
    end

    act(1, 0, 0, '0, 4, "sat.start");
    for (int k = 0; k < 256; k++) begin
      act(0, 1, 0, 10'h001, 4, "sat.pick1");
      act(0, 0, 1, 10'h004, 4, "sat.pick2");
    end
    check("sat.tries", 32'(tries), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_turn_ctrl.md
# tile_turn_ctrl

Turn sequencer for the tile-matching game. It converts raw push-button levels and one-hot tile-select switches into a two-pick turn, and reads both tile values from the board memory. It then compares the values, and maintains the matched/revealed masks, the score and the attempt counter. It sits between the board I/O (SW/KEY) and the board storage/display logic inside `tilegame`.

## Interface
- `NUM_TILES`, default 10: number of tiles, one switch per tile; must be even.
- `VAL_W`, default 4: width of a tile value.
- `REVEAL_CYCLES`, default 4: cycles a mismatched pair stays revealed (≥1).
- `CLOCK_50`  in  1  system clock, all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset (driven from KEY[0]).
- `start_n`  in  1  raw active-low start/restart button (KEY[1]).
- `pick1_n`  in  1  raw active-low first-pick button (KEY[2]).
- `pick2_n`  in  1  raw active-low second-pick button (KEY[3]).
- `sel`  in  NUM_TILES  tile-select switches; a pick is valid only if one-hot.
- `tile_addr`  out  clog2(NUM_TILES)  board memory read address.
- `tile_val`  in  VAL_W  board memory read data, valid 1 cycle after `tile_addr`.
- `matched`  out  NUM_TILES  tiles permanently matched (to LEDR).
- `revealed`  out  NUM_TILES  tiles currently face-up, including matched tiles.
- `score`  out  clog2(NUM_TILES/2)+1  pairs found.
- `tries`  out  8  completed comparisons, saturating at 255.
- `pick_err`  out  1  one-cycle pulse when a pick is rejected.
- `game_over`  out  1  high in DONE.

## Operation
- Each button has a 2-flop synchronizer and a falling-edge detector. The detector gives one press pulse per press, regardless of how long the button is held.
- States: IDLE, WAIT1, READ1, WAIT2, READ2, CMP, SHOW, DONE.
- **IDLE:** a start press clears `matched`, `revealed`, `score`, `tries` and goes to WAIT1.
- **Start press in any other state:** performs the same clear and goes to WAIT1. This is a restart and has priority over every other event in that cycle.
- **WAIT1:** a pick1 press is accepted only if `sel` is one-hot and the selected tile is not matched.
  - On accept: latch the index as `idx1`, drive `tile_addr=idx1`, set `revealed[idx1]`, go to READ1.
  - On reject: pulse `pick_err` and stay in WAIT1.
  - pick2 presses are ignored here.
- **READ1:** latch `tile_val` as `val1`, go to WAIT2.
- **WAIT2:** a pick2 press is accepted only if `sel` is one-hot, the tile is not matched, and the index differs from `idx1`.
  - On accept: latch `idx2`, drive `tile_addr=idx2`, set `revealed[idx2]`, go to READ2.
  - On reject: pulse `pick_err`.
  - pick1 presses are ignored here.
- **READ2:** latch `tile_val` as `val2`, go to CMP.
- **CMP:** increment `tries` (saturating at 255).
  - Equal values: set `matched[idx1]` and `matched[idx2]`, increment `score`. Go to DONE if the new score equals NUM_TILES/2, otherwise go to WAIT1.
  - Unequal values: load the reveal counter with REVEAL_CYCLES-1, go to SHOW.
- **SHOW:** decrement the reveal counter. At 0, clear `revealed[idx1]` and `revealed[idx2]` and go to WAIT1. Button presses other than start are discarded.
- **DONE:** `game_over=1`; only a start press leaves this state.
- Invariant: `matched` is always a subset of `revealed`.

## Timing
- Reset values: state IDLE, `matched=0`, `revealed=0`, `score=0`, `tries=0`, `tile_addr=0`, `pick_err=0`, `game_over=0`, synchronizer flops 1 (buttons released).
- A button falling edge produces its press pulse 3 clocks after the edge (2 sync flops plus the edge register).
- From the first-pick press pulse to WAIT2 takes 2 cycles: WAIT1 → READ1 → WAIT2.
- From the second-pick press pulse to the `matched` update takes 3 cycles; `matched` is registered at the exit of CMP.
- A mismatched pair stays in `revealed` for REVEAL_CYCLES cycles in SHOW.
- Simultaneous pick1 and pick2 pulses: only the one legal in the current state is acted on.
- Reset asserted mid-turn: all outputs return to their reset values immediately (asynchronous).

## Structure
- Shared package `tile_pkg` holds:
  - the state enum;
  - `TILE_IDX_W` derived from NUM_TILES;
  - the one-hot check and one-hot-to-index functions.
- Sub-module `key_edge`, instantiated three times: 2-flop synchronizer plus falling-edge pulse on an active-low button.
- The FSM, masks and counters live in `tile_turn_ctrl`.

## Test plan
All scenarios use a board model where `tile_val = index >> 1`, so tiles 0/1 hold 0, tiles 8/9 hold 4, and so on.
- **Mismatch:** start, `sel=10'b0000000010`, pick1, then `sel=10'b0000000100`, pick2 → `tries=1`, `score=0`, `revealed=10'h006` for 4 cycles then `0`, `matched=0`.
- **Match:** `sel=10'b0100000000` pick1, `sel=10'b1000000000` pick2 → `matched=10'h300`, `score=1`, back in WAIT1.
- **Rejects:** pick1 with `sel=10'b0000000110`, pick1 on an already-matched tile 9, and pick2 with the same tile as pick1 → one `pick_err` pulse each, state unchanged.
- **Full game:** match all 5 pairs → `score=5`, `game_over=1`, `matched=10'h3FF`. A start press then gives all counters 0 and `game_over=0`.
- **Restart and reset mid-turn:** start pressed in SHOW → WAIT1 with all masks cleared. `resetn` pulsed low in READ2 → all outputs at reset values on the same edge.
- **Held button:** pick1 held low for 50 cycles → exactly one press accepted.
